// File: rtl/sync_cell_client.sv
// sync_cell_client: client that performs a single READ, WRITE or ADD on a
// lock-protected shared cell. It requests the lock and waits a bounded number
// of cycles for the grant. It then writes the new value for one cycle,
// releases the lock, waits until the cell drops ownership, and reports the
// value the cell held before the operation.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only when idle)
//   cmd_op, cmd_data               0=READ 1=WRITE 2=ADD 3=READ, operand
//   rsp_valid, rsp_err, rsp_data   one-cycle response, timeout flag, old value
//   lock_req, to_cell              lock request and data presented to the cell
//   is_locked, locked_to           cell lock status and current owner
//   from_cell                      cell contents
module sync_cell_client #(
  parameter int unsigned ACTORS    = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ACTOR_ID  = 0,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [DATA_BITS-1:0]         cmd_data,
  output logic                         rsp_valid,
  output logic                         rsp_err,
  output logic [DATA_BITS-1:0]         rsp_data,
  output logic                         lock_req,
  output logic [DATA_BITS-1:0]         to_cell,
  input  logic                         is_locked,
  input  logic [$clog2(ACTORS+1)-1:0]  locked_to,
  input  logic [DATA_BITS-1:0]         from_cell
);

  localparam int unsigned ID_W  = $clog2(ACTORS + 1);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ADD   = 2'd2;

  // Elaboration-time parameter legality checks
  if (ACTOR_ID >= ACTORS) begin : g_bad_actor_id
    $error("sync_cell_client: ACTOR_ID must be less than ACTORS");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sync_cell_client: TIMEOUT must be at least 1");
  end

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [DATA_BITS-1:0] arg_q, arg_d;
  logic [DATA_BITS-1:0] new_q, new_d;
  logic [DATA_BITS-1:0] old_q, old_d;
  logic [DATA_BITS-1:0] new_val;
  logic [DATA_BITS-1:0] rsp_data_d;
  logic                 rsp_err_d;
  logic                 owned;

  assign owned = is_locked && (locked_to == ID_W'(ACTOR_ID));

  // While requesting, echo the cell so a grant landing mid-request rewrites it unchanged
  assign to_cell = (state_q == S_REQ) ? from_cell : new_q;

  // Value to be written once the lock is held (sum wraps at DATA_BITS)
  always_comb begin
    new_val = from_cell;
    case (op_q)
      OP_WRITE: new_val = arg_q;
      OP_ADD:   new_val = from_cell + arg_q;
      default:  new_val = from_cell;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    arg_d      = arg_q;
    new_d      = new_q;
    old_d      = old_q;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          arg_d   = cmd_data;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (owned) begin
          old_d   = from_cell;
          new_d   = new_val;
          state_d = S_WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        // Losing the lock here means the cell was reset under us
        if (owned) begin
          state_d = S_RELEASE;
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RELEASE: begin
        if (!owned) begin
          rsp_data_d = old_q;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      arg_q     <= '0;
      new_q     <= '0;
      old_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      cmd_ready <= 1'b1;
      lock_req  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      new_q     <= new_d;
      old_q     <= old_d;
      rsp_valid <= (state_d == S_RESP);
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
      cmd_ready <= (state_d == S_IDLE);
      lock_req  <= (state_d == S_REQ) || (state_d == S_WRITE);
    end
  end

endmodule

// File: doc/sync_cell_client.md
SYNC_CELL_CLIENT -- requirements
Module: sync_cell_client

Interface
- REQ-001: Parameters, one per line (name, default, meaning):
  - ACTORS, 4: actors sharing the cell.
  - DATA_BITS, 8: cell data width.
  - ACTOR_ID, 0: this client's index, 0..ACTORS-1.
  - TIMEOUT, 16: maximum cycles spent waiting for a grant, >=1.
- REQ-002: One clock; reset is synchronous and active-high. Ports, one per line (name, direction, width, meaning):
  - clk, in, 1: clock.
  - rst, in, 1: synchronous active-high reset.
  - cmd_valid, in, 1: command request.
  - cmd_ready, out, 1: client idle, command accepted when high with cmd_valid.
  - cmd_op, in, 2: 0=READ, 1=WRITE, 2=ADD, 3=reserved (treated as READ).
  - cmd_data, in, DATA_BITS: operand.
  - rsp_valid, out, 1: one-cycle response pulse.
  - rsp_err, out, 1: grant timed out.
  - rsp_data, out, DATA_BITS: cell value before the operation.
  - lock_req, out, 1: lock request to the cell.
  - to_cell, out, DATA_BITS: data presented to the cell.
  - is_locked, in, 1: cell lock status.
  - locked_to, in, $clog2(ACTORS+1): current lock owner.
  - from_cell, in, DATA_BITS: cell contents.

Function
- REQ-003: Cell contract: the cell grants and updates on the falling clk edge; while locked to this client with lock_req high, it copies to_cell into from_cell every falling edge.
- REQ-004: owned = is_locked && (locked_to == ACTOR_ID), sampled on rising clk.
- REQ-005: FSM states are IDLE, REQ, WRITE, RELEASE and RESP, all transitions on rising clk.
- REQ-006: IDLE behaviour:
  - cmd_ready=1, lock_req=0.
  - On cmd_valid, latch cmd_op and cmd_data, clear the wait counter, and go to REQ.
- REQ-007: REQ behaviour:
  - lock_req=1, to_cell=from_cell (combinational passthrough, so a grant never corrupts the cell).
  - If owned: capture from_cell as old, go to WRITE.
  - Else increment the wait counter.
- REQ-008: Timeout in REQ: if the counter reaches TIMEOUT-1 and the client is not owned, go to RESP with err=1 and old=0. A grant on the same edge wins over the timeout.
- REQ-009: WRITE behaviour:
  - lock_req=1, to_cell=new, registered.
  - new per op: READ: old. WRITE: cmd_data. ADD: (old+cmd_data) mod 2^DATA_BITS; carry discarded.
  - Stays exactly one cycle, then goes to RELEASE.
- REQ-010: RELEASE behaviour:
  - lock_req=0, to_cell holds new.
  - Stays while owned; goes to RESP on the first rising edge where the client is not owned.
- REQ-011: RESP behaviour:
  - rsp_valid=1 for exactly one cycle, rsp_data=old, rsp_err=err.
  - Next state is IDLE.
  - There is no response backpressure.
- REQ-012: cmd_ready is high only in IDLE; commands presented in other states are ignored.
- REQ-013: Uncontended latency: command accepted at edge E0 means grant at E1, write latched at the falling edge after E1, release visible at E3, and rsp_valid high in the cycle after E3 (4 cycles).
- REQ-014: Under contention, the added latency equals the cycles spent waiting in REQ; a lower-ID owner is never preempted.
- REQ-015: lock_req shall never be high outside REQ and WRITE.
- REQ-016: When owned, to_cell shall never present a value other than from_cell (REQ) or new (WRITE).
- REQ-017: An ownership loss observed in WRITE (cell reset) shall abort to RESP with err=1 and old=0.
- REQ-018: ACTOR_ID >= ACTORS is illegal and shall be flagged by an elaboration-time check.

Reset
- REQ-019: With rst high at a rising edge, state=IDLE and lock_req=0, so the cell releases at the next falling edge.
- REQ-020: Reset values are rsp_valid=0, rsp_err=0, rsp_data=0, to_cell=0 and wait counter=0; cmd_ready=1 from the first cycle after reset.
- REQ-021: Reset mid-transaction (any state) produces no response and leaves the cell unchanged except by any WRITE already latched.

Verification
- REQ-022: Uncontended ADD: cell=0x05, ADD 0x03 -> rsp_valid 4 cycles after acceptance, rsp_data=0x05, cell=0x08, rsp_err=0.
- REQ-023: Wrap: cell=0xFF, ADD 0x02 (DATA_BITS=8) -> cell=0x01, rsp_data=0xFF.
- REQ-024: Contention: ACTOR_ID=2 while actor 0 holds the lock for 5 cycles -> grant only after release, cell unchanged during the wait, response 5 cycles later than uncontended.
- REQ-025: Timeout: TIMEOUT=4 with the lock held by another actor -> rsp_err=1 and rsp_data=0 after 4 REQ cycles; lock_req drops; the cell is untouched.
- REQ-026: Grant and timeout on the same edge -> the operation completes with rsp_err=0.
- REQ-027: rst asserted in WRITE -> lock_req=0 next cycle, no rsp_valid, cmd_ready=1, and the cell releases.
